// File: rtl/pa_tx_mc_pkg.sv
// Shared descriptor encodings, message/PD field offsets and the queued PD entry type.
package pa_tx_mc_pkg;

    // Forwarding destinations.
    localparam logic [3:0] VAL_FWD_DROP = 4'h1;
    localparam logic [3:0] VAL_FWD_MAC  = 4'h2;
    localparam logic [3:0] VAL_FWD_TOE  = 4'h4;
    localparam logic [3:0] VAL_FWD_APP  = 4'h8;

    // Packet types.
    localparam logic [7:0] VAL_PTYP_PKT_SYN          = 8'h02;
    localparam logic [7:0] VAL_PTYP_PKT_SYNACK       = 8'h12;
    localparam logic [7:0] VAL_PTYP_MAC              = 8'h20;
    localparam logic [7:0] VAL_PTYP_PKT_MSG          = 8'h30;
    localparam logic [7:0] VAL_PTYP_DROP_TOE_TX_ERR  = 8'hf0;
    localparam logic [7:0] VAL_PTYP_DROP_SHORT_PKT   = 8'hf1;
    localparam logic [7:0] VAL_PTYP_DROP_CPU_LOOP    = 8'hf2;

    // Message field offsets; the last three are relative to MSG_WID.
    localparam int unsigned MSG_SOC_BIT  = 3;
    localparam int unsigned MSG_ERR_BIT  = 11;
    localparam int unsigned MSG_FID_LSB  = 16;
    localparam int unsigned MSG_SEQN_LSB = 32;
    localparam int unsigned MSG_ACKN_LSB = 64;
    localparam int unsigned MSG_CKS_OFS  = 0;
    localparam int unsigned MSG_PLEN_OFS = 16;
    localparam int unsigned MSG_PPTR_OFS = 32;

    // PD beat field offsets.
    localparam int unsigned PD_FWD_LSB   = 124;
    localparam int unsigned PD_PTYP_LSB  = 116;
    localparam int unsigned PD_TFID_LSB  = 96;
    localparam int unsigned PD_PPTR_LSB  = 80;
    localparam int unsigned PD_PLEN_LSB  = 64;
    localparam int unsigned PD_CHN_LSB   = 60;
    localparam int unsigned PD_CKS_LSB   = 28;
    localparam int unsigned PD_OPORT_LSB = 24;
    localparam int unsigned PD_SEQN_LSB  = 48;
    localparam int unsigned PD_ACKN_LSB  = 16;

    // Classified fields held per queued PD; all constant-zero fields are left out.
    typedef struct packed {
        logic [3:0]  fwd;
        logic [7:0]  ptyp;
        logic [15:0] tcp_fid;
        logic [11:0] pptr;
        logic [15:0] plen;
        logic [3:0]  chn_id;
        logic [15:0] tmp_cks;
        logic [3:0]  oport;
        logic [31:0] seqn;
        logic [31:0] ackn;
    } pd_entry_t;

    // Build one 128-bit PD beat; non-first beats carry seqn/ackn over the middle fields.
    function automatic logic [127:0] pd_beat(pd_entry_t e, logic first);
        logic [127:0] b;
        b = '0;
        b[PD_FWD_LSB   +: 4]  = e.fwd;
        b[PD_PTYP_LSB  +: 8]  = e.ptyp;
        b[PD_TFID_LSB  +: 16] = e.tcp_fid;
        b[PD_PPTR_LSB  +: 12] = e.pptr;
        b[PD_PLEN_LSB  +: 16] = e.plen;
        b[PD_CHN_LSB   +: 4]  = e.chn_id;
        b[PD_CKS_LSB   +: 16] = e.tmp_cks;
        b[PD_OPORT_LSB +: 4]  = e.oport;
        if (!first) begin
            b[PD_SEQN_LSB +: 32] = e.seqn;
            b[PD_ACKN_LSB +: 32] = e.ackn;
        end
        return b;
    endfunction

endpackage

// File: rtl/pa_tx_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, advances on accept.
module pa_tx_rr_arb
    import pa_tx_mc_pkg::*;
#(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned IDXW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] req,
    input  logic              accept,
    output logic [CH_NUM-1:0] gnt,
    output logic [IDXW-1:0]   gnt_idx,
    output logic              gnt_vld
);

    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    int unsigned     idx;

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            idx = (int'(rr_ptr_q) + i) % CH_NUM;
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IDXW'(idx);
                gnt[idx] = 1'b1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (accept && gnt_vld) begin
            rr_ptr_d = IDXW'((int'(gnt_idx) + 1) % CH_NUM);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/pa_tx_mc.sv
// Multi-channel PD generator: RR arbitration of soc cells, classification, queue and
// multi-beat PD serialiser with per-beat back-pressure.
module pa_tx_mc
    import pa_tx_mc_pkg::*;
#(
    parameter int unsigned DWID     = 256,
    parameter int unsigned MSG_WID  = 96,
    parameter int unsigned FCMWID   = 140,
    parameter int unsigned PDWID    = 128,
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned PD_BEATS = 4,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM-1:0]        fst_cell_vld,
    output logic [CH_NUM-1:0]        fst_cell_rdy,
    input  logic [CH_NUM*DWID-1:0]   fst_cell_dat,
    input  logic [CH_NUM*FCMWID-1:0] fst_cell_msg,
    output logic                     out_pd_vld,
    input  logic                     out_pd_rdy,
    output logic [PDWID-1:0]         out_pd_dat,
    output logic                     out_pd_sop,
    output logic                     out_pd_eop,
    output logic [31:0]              drop_cnt,
    output logic                     q_full
);

    localparam int unsigned IDXW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned QAW  = $clog2(QDEPTH);
    localparam int unsigned BCW  = $clog2(PD_BEATS);

    logic [CH_NUM-1:0] req, gnt, rdy_int;
    logic [IDXW-1:0]   gnt_idx;
    logic              gnt_vld, space, push, pop, hs, last, empty;
    logic [FCMWID-1:0] sel_msg;
    logic [DWID-1:0]   sel_dat;
    logic [15:0]       fid, plen, dfid;
    logic [7:0]        dptyp, ptyp_toe;
    pd_entry_t         new_e, head;
    pd_entry_t         mem [QDEPTH];
    logic [QAW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [QAW:0]      cnt_q, cnt_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;

    // Only soc cells compete; everything else is consumed immediately.
    always_comb begin
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            req[c] = fst_cell_vld[c] & fst_cell_msg[c*FCMWID + MSG_SOC_BIT];
        end
    end

    // A full queue still accepts when the head PD is leaving this cycle.
    assign space = !q_full || pop;
    assign push  = gnt_vld && space;

    pa_tx_rr_arb #(
        .CH_NUM (CH_NUM),
        .IDXW   (IDXW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .accept  (push),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign rdy_int      = ~req | (gnt & {CH_NUM{space}});
    assign fst_cell_rdy = rst_n ? rdy_int : '0;
    assign sel_msg      = fst_cell_msg[gnt_idx*FCMWID +: FCMWID];
    assign sel_dat      = fst_cell_dat[gnt_idx*DWID +: DWID];

    // Classify the granted cell into a queue entry.
    always_comb begin
        fid      = sel_msg[MSG_FID_LSB +: 16];
        plen     = sel_msg[MSG_WID + MSG_PLEN_OFS +: 16];
        dptyp    = sel_dat[DWID-8 +: 8];
        dfid     = sel_dat[DWID-24 +: 16];
        ptyp_toe = (dptyp == VAL_PTYP_PKT_SYN) ? VAL_PTYP_PKT_SYNACK : dptyp;
        new_e    = '0;
        if (sel_msg[MSG_ERR_BIT]) begin
            new_e.fwd  = VAL_FWD_DROP;
            new_e.ptyp = VAL_PTYP_DROP_TOE_TX_ERR;
        end else if (fid < 16'd3 && plen <= 16'd32) begin
            new_e.fwd  = VAL_FWD_DROP;
            new_e.ptyp = VAL_PTYP_DROP_SHORT_PKT;
        end else if (fid < 16'd3) begin
            new_e.fwd  = VAL_FWD_MAC;
            new_e.ptyp = VAL_PTYP_MAC;
        end else if (fid == 16'd3) begin
            new_e.fwd  = VAL_FWD_DROP;
            new_e.ptyp = VAL_PTYP_DROP_CPU_LOOP;
        end else if (fid == 16'd8) begin
            new_e.fwd  = VAL_FWD_TOE;
            new_e.ptyp = ptyp_toe;
        end else begin
            new_e.fwd  = VAL_FWD_APP;
            new_e.ptyp = VAL_PTYP_PKT_MSG;
        end
        new_e.tcp_fid = (new_e.fwd == VAL_FWD_TOE || new_e.fwd == VAL_FWD_DROP) ? dfid : fid;
        new_e.tmp_cks = (new_e.fwd == VAL_FWD_APP) ? sel_msg[MSG_WID + MSG_CKS_OFS +: 16] : 16'd0;
        new_e.oport   = (new_e.fwd == VAL_FWD_MAC) ? fid[3:0] : {2'b00, new_e.tcp_fid[15:14]};
        new_e.pptr    = sel_msg[MSG_WID + MSG_PPTR_OFS +: 12];
        new_e.plen    = plen;
        new_e.chn_id  = 4'(gnt_idx);
        new_e.seqn    = sel_msg[MSG_SEQN_LSB +: 32];
        new_e.ackn    = sel_msg[MSG_ACKN_LSB +: 32];
    end

    assign empty      = (cnt_q == '0);
    assign q_full     = (cnt_q == (QAW+1)'(QDEPTH));
    assign head       = mem[rd_ptr_q];
    assign last       = (beat_q == BCW'(PD_BEATS-1));
    assign out_pd_vld = !empty;
    assign hs         = out_pd_vld && out_pd_rdy;
    assign pop        = hs && last;
    assign out_pd_sop = out_pd_vld && (beat_q == '0);
    assign out_pd_eop = out_pd_vld && last;
    assign out_pd_dat = out_pd_vld ? PDWID'(pd_beat(head, beat_q == '0)) : '0;
    assign drop_cnt   = drop_cnt_q;

    // Next-state for occupancy, beat counter and saturating drop counter.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        beat_d = beat_q;
        if (hs) begin
            beat_d = last ? '0 : beat_q + 1'b1;
        end
        drop_cnt_d = drop_cnt_q;
        if (hs && beat_q == '0 && head.fwd == VAL_FWD_DROP && drop_cnt_q != 32'hffff_ffff) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    // Control state; reset discards queued PDs and any PD in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= new_e;
        end
    end

endmodule

// File: tb/tb_pa_tx_mc.sv
// Scoreboard bench for pa_tx_mc: expected PDs pushed on cell acceptance, compared per beat.
module tb_pa_tx_mc;
    import pa_tx_mc_pkg::*;

    localparam int DWID = 256, MSG_WID = 96, FCMWID = 140, PDWID = 128;
    localparam int CH_NUM = 4, PD_BEATS = 4, QDEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [CH_NUM-1:0]        cell_vld, cell_rdy;
    logic [CH_NUM*DWID-1:0]   cell_dat;
    logic [CH_NUM*FCMWID-1:0] cell_msg;
    logic                     out_pd_vld, out_pd_rdy, out_pd_sop, out_pd_eop, q_full_w;
    logic [PDWID-1:0]         out_pd_dat;
    logic [31:0]              drop_cnt;

    always #5 clk = ~clk;

    pa_tx_mc #(
        .DWID (DWID), .MSG_WID (MSG_WID), .FCMWID (FCMWID), .PDWID (PDWID),
        .CH_NUM (CH_NUM), .PD_BEATS (PD_BEATS), .QDEPTH (QDEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fst_cell_vld (cell_vld),
        .fst_cell_rdy (cell_rdy),
        .fst_cell_dat (cell_dat),
        .fst_cell_msg (cell_msg),
        .out_pd_vld   (out_pd_vld),
        .out_pd_rdy   (out_pd_rdy),
        .out_pd_dat   (out_pd_dat),
        .out_pd_sop   (out_pd_sop),
        .out_pd_eop   (out_pd_eop),
        .drop_cnt     (drop_cnt),
        .q_full       (q_full_w)
    );

    typedef struct {
        logic [3:0]  fwd;
        logic [7:0]  ptyp;
        logic [15:0] tcp_fid;
        logic [11:0] pptr;
        logic [15:0] plen;
        logic [3:0]  chn;
        logic [15:0] cks;
        logic [3:0]  oport;
        logic [31:0] seqn;
        logic [31:0] ackn;
        int          acc_cyc;
        bit          imm;
    } exp_t;

    exp_t              sb[$];
    int                gnt_log[$];
    int                checks = 0, failures = 0, cyc = 0, tb_beat = 0;
    int                pushes = 0, pops = 0;
    bit                lat_done = 0;
    logic [31:0]       drops = 0;
    logic [CH_NUM-1:0] acc = '0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FCMWID-1:0] mk_msg(bit soc, bit err, logic [15:0] fid,
            logic [31:0] seqn, logic [31:0] ackn, logic [15:0] cks, logic [15:0] plen,
            logic [11:0] pptr);
        logic [FCMWID-1:0] m;
        m = '0;
        for (int i = 0; i < FCMWID / 32; i++) m[i*32 +: 32] = $urandom;
        m[3] = soc;
        m[11] = err;
        m[31:16] = fid;
        m[63:32] = seqn;
        m[95:64] = ackn;
        m[MSG_WID +: 16] = cks;
        m[MSG_WID+16 +: 16] = plen;
        m[MSG_WID+32 +: 12] = pptr;
        return m;
    endfunction

    function automatic logic [DWID-1:0] mk_dat(logic [7:0] ptyp, logic [15:0] dfid);
        logic [DWID-1:0] d;
        for (int i = 0; i < DWID / 32; i++) d[i*32 +: 32] = $urandom;
        d[DWID-1 -: 8] = ptyp;
        d[DWID-9 -: 16] = dfid;
        return d;
    endfunction

    // Reference classification straight from the field definitions.
    function automatic exp_t model(int ch, logic [FCMWID-1:0] m, logic [DWID-1:0] d);
        exp_t e;
        logic [15:0] fid, plen, dfid;
        logic [7:0] dptyp;
        fid = m[31:16];
        plen = m[MSG_WID+16 +: 16];
        dptyp = d[DWID-1 -: 8];
        dfid = d[DWID-9 -: 16];
        if (m[11]) begin
            e.fwd = VAL_FWD_DROP; e.ptyp = VAL_PTYP_DROP_TOE_TX_ERR;
        end else if (fid <= 2 && plen <= 32) begin
            e.fwd = VAL_FWD_DROP; e.ptyp = VAL_PTYP_DROP_SHORT_PKT;
        end else if (fid <= 2) begin
            e.fwd = VAL_FWD_MAC; e.ptyp = VAL_PTYP_MAC;
        end else if (fid == 3) begin
            e.fwd = VAL_FWD_DROP; e.ptyp = VAL_PTYP_DROP_CPU_LOOP;
        end else if (fid == 8) begin
            e.fwd = VAL_FWD_TOE;
            e.ptyp = (dptyp == VAL_PTYP_PKT_SYN) ? VAL_PTYP_PKT_SYNACK : dptyp;
        end else begin
            e.fwd = VAL_FWD_APP; e.ptyp = VAL_PTYP_PKT_MSG;
        end
        e.tcp_fid = (e.fwd == VAL_FWD_TOE || e.fwd == VAL_FWD_DROP) ? dfid : fid;
        e.cks = (e.fwd == VAL_FWD_APP) ? m[MSG_WID +: 16] : 16'd0;
        e.oport = (e.fwd == VAL_FWD_MAC) ? fid[3:0] : {2'b00, e.tcp_fid[15:14]};
        e.pptr = m[MSG_WID+32 +: 12];
        e.plen = plen;
        e.chn = 4'(ch);
        e.seqn = m[63:32];
        e.ackn = m[95:64];
        e.acc_cyc = 0;
        e.imm = 0;
        return e;
    endfunction

    function automatic logic [127:0] exp_beat(exp_t e, int b);
        logic [127:0] r;
        r = '0;
        r[127:124] = e.fwd;
        r[123:116] = e.ptyp;
        r[111:96] = e.tcp_fid;
        r[91:80] = e.pptr;
        r[79:64] = e.plen;
        r[63:60] = e.chn;
        r[43:28] = e.cks;
        r[27:24] = e.oport;
        if (b != 0) begin
            r[79:48] = e.seqn;
            r[47:16] = e.ackn;
        end
        return r;
    endfunction

    // Monitor: compare output beats against the scoreboard head, then log acceptances.
    always @(negedge clk) begin
        exp_t e;
        int sz0, n;
        if (!rst_n) begin
            sb.delete();
            tb_beat = 0;
            drops = 0;
            acc = '0;
            lat_done = 0;
        end else begin
            sz0 = sb.size();
            check_eq("q_full", q_full_w, sz0 == QDEPTH);
            check_eq("drop_cnt", drop_cnt, drops);
            if (out_pd_vld) begin
                if (sz0 == 0) begin
                    check_eq("spurious_vld", out_pd_vld, 0);
                end else begin
                    if (tb_beat == 0 && sb[0].imm && !lat_done) begin
                        check_eq("latency", cyc - sb[0].acc_cyc, 1);
                        lat_done = 1;
                    end
                    check_eq($sformatf("dat_b%0d", tb_beat), out_pd_dat, exp_beat(sb[0], tb_beat));
                    check_eq("sop", out_pd_sop, tb_beat == 0);
                    check_eq("eop", out_pd_eop, tb_beat == PD_BEATS - 1);
                    if (out_pd_rdy) begin
                        if (tb_beat == 0 && sb[0].fwd == VAL_FWD_DROP && drops != 32'hffff_ffff)
                            drops++;
                        if (tb_beat == PD_BEATS - 1) begin
                            void'(sb.pop_front());
                            tb_beat = 0;
                            pops++;
                            lat_done = 0;
                        end else begin
                            tb_beat++;
                        end
                    end
                end
            end else if (sz0 != 0) begin
                check_eq("vld", out_pd_vld, 1);
            end
            acc = cell_vld & cell_rdy;
            n = 0;
            for (int c = 0; c < CH_NUM; c++) begin
                if (acc[c] && cell_msg[c*FCMWID + 3]) begin
                    e = model(c, cell_msg[c*FCMWID +: FCMWID], cell_dat[c*DWID +: DWID]);
                    e.acc_cyc = cyc;
                    e.imm = (sb.size() == 0);
                    sb.push_back(e);
                    gnt_log.push_back(c);
                    pushes++;
                    n++;
                end
            end
            if (n != 0) check_eq("one_grant", n, 1);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cell_vld = cell_vld & ~acc;
    endtask

    task automatic put(input int ch, input logic [FCMWID-1:0] m, input logic [DWID-1:0] d);
        cell_msg[ch*FCMWID +: FCMWID] = m;
        cell_dat[ch*DWID +: DWID] = d;
        cell_vld[ch] = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((cell_vld != 0 || sb.size() != 0 || out_pd_vld) && n < 500) begin
            tick();
            n++;
        end
        check_eq({tag, "_drain"}, n < 500, 1);
    endtask

    initial begin
        int n, p0, q0;
        rst_n = 1'b0;
        cell_vld = '0;
        cell_msg = '0;
        cell_dat = '0;
        out_pd_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_vld", out_pd_vld, 0);
        check_eq("rst_dat", out_pd_dat, 0);
        check_eq("rst_sop", out_pd_sop, 0);
        check_eq("rst_eop", out_pd_eop, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_qfull", q_full_w, 0);
        check_eq("rst_cell_rdy", cell_rdy, 0);
        rst_n = 1'b1;
        tick();

        // Round robin: all four together, then ch1+ch0 after the pointer has wrapped.
        gnt_log.delete();
        for (int c = 0; c < CH_NUM; c++)
            put(c, mk_msg(1, 0, 16'h0100 + 16'(c), 32'(c), 32'h1000 + 32'(c), 16'hbeef, 16'd200,
                          12'(c)), mk_dat(8'h44, 16'h4000));
        wait_idle("rr4");
        for (int i = 0; i < 4; i++)
            check_eq("rr_order4", i < gnt_log.size() ? gnt_log[i] : -1, i);
        gnt_log.delete();
        put(1, mk_msg(1, 0, 16'h0009, 32'h1, 32'h2, 16'h1234, 16'd64, 12'h111), mk_dat(8'h1, 16'h1));
        put(0, mk_msg(1, 0, 16'h000a, 32'h3, 32'h4, 16'h5678, 16'd64, 12'h222), mk_dat(8'h1, 16'h2));
        wait_idle("rr2");
        for (int i = 0; i < 2; i++)
            check_eq("rr_order_wrap", i < gnt_log.size() ? gnt_log[i] : -1, i);

        // TOE SYN -> SYNACK with seqn/ackn on later beats.
        put(0, mk_msg(1, 0, 16'd8, 32'h11223344, 32'h55667788, 16'h0, 16'd100, 12'habc),
            mk_dat(VAL_PTYP_PKT_SYN, 16'h8123));
        wait_idle("toe");

        // Short-packet boundary: plen 32 drops, 33 goes to MAC.
        put(2, mk_msg(1, 0, 16'd1, 32'h5, 32'h6, 16'h7, 16'd32, 12'h3), mk_dat(8'h9, 16'hc0de));
        wait_idle("short");
        check_eq("drop_cnt_1", drop_cnt, 1);
        put(2, mk_msg(1, 0, 16'd1, 32'h5, 32'h6, 16'h7, 16'd33, 12'h3), mk_dat(8'h9, 16'hc0de));
        wait_idle("mac");

        // Remaining classes: error, CPU loop, TOE non-SYN, APP with checksum.
        put(1, mk_msg(1, 1, 16'd8, 32'h7, 32'h8, 16'h9, 16'd500, 12'h4), mk_dat(8'h3, 16'h7777));
        put(3, mk_msg(1, 0, 16'd3, 32'h9, 32'ha, 16'hb, 16'd500, 12'h5), mk_dat(8'h3, 16'h4242));
        wait_idle("drops");
        check_eq("drop_cnt_3", drop_cnt, 3);
        put(3, mk_msg(1, 0, 16'd8, 32'hc, 32'hd, 16'he, 16'd70, 12'h6), mk_dat(8'h33, 16'hf00f));
        put(1, mk_msg(1, 0, 16'h1234, 32'hf, 32'h10, 16'hcafe, 16'd70, 12'h7), mk_dat(8'h3, 16'h1));
        wait_idle("toe_app");

        // Back-pressure at beat 2 for five cycles.
        put(1, mk_msg(1, 0, 16'h0055, 32'hdead0001, 32'hbeef0002, 16'h4321, 16'd90, 12'h8),
            mk_dat(8'h0, 16'h0));
        n = 0;
        while (!(out_pd_vld && tb_beat == 2) && n < 50) begin tick(); n++; end
        check_eq("bp_reach_beat2", n < 50, 1);
        out_pd_rdy = 1'b0;
        p0 = pops;
        repeat (5) tick();
        check_eq("bp_sop_held", out_pd_sop, 0);
        check_eq("bp_no_pop", pops - p0, 0);
        out_pd_rdy = 1'b1;
        wait_idle("bp");

        // Fill the queue with the output stalled; a fifth cell must wait.
        out_pd_rdy = 1'b0;
        p0 = pushes;
        q0 = pops;
        for (int c = 0; c < CH_NUM; c++)
            put(c, mk_msg(1, 0, 16'h0200 + 16'(c), 32'h100 + 32'(c), 32'h200 + 32'(c), 16'h1,
                          16'd40, 12'(c)), mk_dat(8'h5, 16'h0));
        n = 0;
        while (cell_vld != 0 && n < 20) begin tick(); n++; end
        check_eq("full_accept4", pushes - p0, 4);
        check_eq("full_flag", q_full_w, 1);
        put(0, mk_msg(1, 0, 16'h0300, 32'h999, 32'h888, 16'h2, 16'd40, 12'h9), mk_dat(8'h5, 16'h0));
        repeat (3) tick();
        check_eq("full_blocks_rdy", cell_rdy[0], 0);
        check_eq("full_5th_waiting", cell_vld[0], 1);
        out_pd_rdy = 1'b1;
        wait_idle("full");
        check_eq("full_pushes", pushes - p0, 5);
        check_eq("full_pops", pops - q0, 5);

        // Non-soc cell is consumed and produces nothing.
        p0 = pushes;
        put(2, mk_msg(0, 0, 16'd8, 32'h1, 32'h1, 16'h1, 16'd100, 12'h1), mk_dat(8'h1, 16'h1));
        tick();
        check_eq("nonsoc_consumed", cell_vld[2], 0);
        wait_idle("nonsoc");
        check_eq("nonsoc_no_pd", pushes - p0, 0);

        // Reset in the middle of a PD.
        put(3, mk_msg(1, 0, 16'd2, 32'h77, 32'h66, 16'h5, 16'd100, 12'h3), mk_dat(8'h1, 16'h1));
        n = 0;
        while (!(out_pd_vld && tb_beat == 1) && n < 50) begin tick(); n++; end
        check_eq("rst_reach_beat1", n < 50, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld", out_pd_vld, 0);
        check_eq("mid_rst_dat", out_pd_dat, 0);
        check_eq("mid_rst_sop", out_pd_sop, 0);
        check_eq("mid_rst_eop", out_pd_eop, 0);
        check_eq("mid_rst_drop", drop_cnt, 0);
        check_eq("mid_rst_qfull", q_full_w, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("post_rst_idle", out_pd_vld, 0);
        put(0, mk_msg(1, 0, 16'd8, 32'haaaa5555, 32'h5555aaaa, 16'h0, 16'd60, 12'h1),
            mk_dat(8'h33, 16'h2468));
        wait_idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
